mux_2_to_1_rr_arbiter: RTL and testbench
========================================

// Module: mux_2_to_1_rr_arbiter
// PURPOSE
//   Shares one output channel between two valid/ready requesters.
//   Round-robin arbitration grants whole bursts, terminated by last or by a beat cap.
//   The granted port's data passes through a 2-to-1 datapath mux into a
//   one-entry output register.
//   Sits in front of any single-consumer sink that needs two producers.
// PARAMETERS
//   WIDTH      8   data bits per beat
//   MAX_BURST  4   max beats per grant before forced release (>=1)
// PORTS
//   clk         in   1      single clock, rising edge
//   rst_n       in   1      asynchronous, active-low reset
//   req0_valid  in   1      requester 0 has a beat
//   req0_data   in   WIDTH  requester 0 beat data
//   req0_last   in   1      requester 0 final beat of burst
//   req0_ready  out  1      requester 0 beat accepted this cycle
//   req1_valid  in   1      requester 1 has a beat
//   req1_data   in   WIDTH  requester 1 beat data
//   req1_last   in   1      requester 1 final beat of burst
//   req1_ready  out  1      requester 1 beat accepted this cycle
//   out_valid   out  1      output register holds a beat
//   out_data    out  WIDTH  output beat data
//   out_last    out  1      output beat is last of burst
//   out_ready   in   1      sink accepts output beat
//   sel         out  1      current mux select (1 = requester 1)
//   busy        out  1      a grant is active (state != IDLE)
// BEHAVIOUR
//   Reset (async, rst_n=0):
//     - state=IDLE, prio=0, sel=0, beat_cnt=0
//     - out_valid=0, out_data=0, out_last=0
//     - any in-flight beat is discarded.
//   FSM states: IDLE, OWN0, OWN1.
//   IDLE:
//     - both valid: grant requester prio.
//     - one valid: grant that one.
//     - none valid: stay in IDLE.
//     - Arbitration costs one cycle.
//   OWNn:
//     - reqn_ready = (!out_valid || out_ready); other port's ready = 0.
//     - In IDLE both readies are 0.
//     - Beat accept: reqn_valid && reqn_ready. Next edge loads
//       out_data/out_last from the mux and sets out_valid=1. Latency is 1 cycle.
//     - Output drain: out_valid && out_ready && no new accept -> out_valid=0.
//       Simultaneous drain and accept -> register reloads, out_valid stays 1 (full throughput).
//   beat_cnt ($clog2(MAX_BURST+1) bits):
//     - increments per accepted beat.
//     - Release happens on an accepted beat with last=1, or on the MAX_BURST-th accept.
//     - On release: next=IDLE, beat_cnt=0, prio=~n.
//     - If the cap forces release without last, out_last still mirrors reqn_last (0).
//   Owner behaviour:
//     - An owner dropping valid mid-burst keeps the grant (no timeout).
//     - Data must stay stable while valid && !ready.
//   sel:
//     - =1 in OWN1, =0 in OWN0.
//     - Holds its last value in IDLE.
//   Back-pressure: out_ready=0 with out_valid=1 -> reqn_ready=0, register holds.
//   Release and other-requester valid in the same cycle: IDLE for 1 cycle,
//   then grant goes to the other requester (prio).
// STRUCTURE
//   Package mux_arb_pkg:
//     - state encoding localparams IDLE=2'd0, OWN0=2'd1, OWN1=2'd2
//     - function to derive the beat_cnt width.
//   Sub-module: the WIDTH+1-bit datapath select ({data,last}) is a generate loop of
//   existing mux_2_to_1 instances driven by sel.
//   FSM, counter, prio and output register stay in this module.
// TESTING
//   1. Reset with both valid high; release rst_n.
//      -> cycle 1 IDLE; OWN0 granted; req0 beats 0x11,0x22(last) appear on out_data
//         one cycle after accept; sel=0.
//   2. Both stream continuously with last never set, MAX_BURST=4.
//      -> 4 beats from 0, 1 idle cycle, 4 beats from 1, alternating; sel toggles.
//   3. out_ready=0 for 5 cycles while out_valid=1.
//      -> out_data held, req0_ready=0.
//      On out_ready=1: 1 beat/cycle, no loss or duplicate.
//   4. Only req1 requests, single-beat bursts 0xA0..0xA3.
//      -> every burst granted to 1, with 1 IDLE cycle between bursts.
//   5. rst_n low mid-burst with out_valid=1.
//      -> out_valid=0 and busy=0 immediately (async).
//      After release, prio=0 and beat_cnt=0.
//   6. Owner drops valid for 3 cycles mid-burst while other is valid.
//      -> grant kept (busy=1, sel unchanged); burst resumes, then prio switches.

Source files
------------

// File: rtl/mux_2_to_1_rr_arbiter_pkg.sv
// +----------------------------------------------------------------------+
// | mux_arb_pkg: state encoding and sizing helper for the 2:1 RR arbiter |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package mux_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_e;

    // Counter must be able to hold 0..MAX_BURST.
    function automatic int cnt_width(input int max_burst);
        return $clog2(max_burst + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mux_2_to_1_rr_arbiter_if.sv
// +----------------------------------------------------------------------+
// | mux_2_to_1_rr_arbiter_if: two requester channels, output, status     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

interface mux_2_to_1_rr_arbiter_if #(
    parameter int WIDTH = 8
);
    logic             req0_valid;
    logic [WIDTH-1:0] req0_data;
    logic             req0_last;
    logic             req0_ready;
    logic             req1_valid;
    logic [WIDTH-1:0] req1_data;
    logic             req1_last;
    logic             req1_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_last;
    logic             out_ready;
    logic             sel;
    logic             busy;

    modport slave (
        input  req0_valid, req0_data, req0_last,
        output req0_ready,
        input  req1_valid, req1_data, req1_last,
        output req1_ready,
        output out_valid, out_data, out_last,
        input  out_ready,
        output sel, busy
    );

    modport master (
        output req0_valid, req0_data, req0_last,
        input  req0_ready,
        output req1_valid, req1_data, req1_last,
        input  req1_ready,
        input  out_valid, out_data, out_last,
        output out_ready,
        input  sel, busy
    );
endinterface

`default_nettype wire

// File: rtl/mux_2_to_1.sv
// +----------------------------------------------------------------------+
// | mux_2_to_1: single-bit 2-to-1 multiplexer                            |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module mux_2_to_1 (
    input  wire logic in0_i,
    input  wire logic in1_i,
    input  wire logic sel_i,
    output logic      out_o
);
    assign out_o = sel_i ? in1_i : in0_i;
endmodule

`default_nettype wire

// File: rtl/mux_2_to_1_rr_arbiter_dp.sv
// +----------------------------------------------------------------------+
// | mux_2_to_1_rr_arbiter_dp: bitwise {data,last} select via mux_2_to_1  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module mux_2_to_1_rr_arbiter_dp #(
    parameter int WIDTH = 8
) (
    input  wire logic [WIDTH:0] in0_i,
    input  wire logic [WIDTH:0] in1_i,
    input  wire logic           sel_i,
    output logic      [WIDTH:0] out_o
);
    for (genvar i = 0; i <= WIDTH; i++) begin : g_bit
        mux_2_to_1 u_mux (
            .in0_i (in0_i[i]),
            .in1_i (in1_i[i]),
            .sel_i (sel_i),
            .out_o (out_o[i])
        );
    end
endmodule

`default_nettype wire

// File: rtl/mux_2_to_1_rr_arbiter.sv
// +----------------------------------------------------------------------+
// | mux_2_to_1_rr_arbiter: round-robin burst arbiter, 2 requesters into  |
// | one registered output. Rev 1.0                                       |
// +----------------------------------------------------------------------+
`default_nettype none

module mux_2_to_1_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    mux_2_to_1_rr_arbiter_if.slave  bus
);
    localparam int                 c_CNT_W = cnt_width(MAX_BURST);
    localparam logic [c_CNT_W-1:0] c_CAP   = c_CNT_W'(MAX_BURST - 1);

    state_e             state_q, state_d;
    logic               prio_q, prio_d;
    logic               sel_q, sel_d;
    logic [c_CNT_W-1:0] cnt_q, cnt_d;
    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   out_data_q, out_data_d;
    logic               out_last_q, out_last_d;

    logic [WIDTH:0]     w_mux_out;
    logic               w_can_load;
    logic               w_accept;

    mux_2_to_1_rr_arbiter_dp #(.WIDTH(WIDTH)) u_dp (
        .in0_i ({bus.req0_data, bus.req0_last}),
        .in1_i ({bus.req1_data, bus.req1_last}),
        .sel_i (sel_q),
        .out_o (w_mux_out)
    );

    assign w_can_load = !out_valid_q || bus.out_ready;

    always_comb begin
        state_d        = state_q;
        prio_d         = prio_q;
        sel_d          = sel_q;
        cnt_d          = cnt_q;
        out_valid_d    = out_valid_q;
        out_data_d     = out_data_q;
        out_last_d     = out_last_q;
        bus.req0_ready = 1'b0;
        bus.req1_ready = 1'b0;
        w_accept       = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.req0_valid && bus.req1_valid) begin
                    state_d = prio_q ? OWN1 : OWN0;
                    sel_d   = prio_q;
                end else if (bus.req0_valid) begin
                    state_d = OWN0;
                    sel_d   = 1'b0;
                end else if (bus.req1_valid) begin
                    state_d = OWN1;
                    sel_d   = 1'b1;
                end
            end
            OWN0: begin
                bus.req0_ready = w_can_load;
                w_accept       = bus.req0_valid && w_can_load;
            end
            OWN1: begin
                bus.req1_ready = w_can_load;
                w_accept       = bus.req1_valid && w_can_load;
            end
            default: state_d = IDLE;
        endcase

        // sel_q equals the owner here, so the mux already carries the owner's beat.
        if (w_accept) begin
            out_valid_d              = 1'b1;
            {out_data_d, out_last_d} = w_mux_out;
            if (w_mux_out[0] || (cnt_q == c_CAP)) begin
                state_d = IDLE;
                cnt_d   = '0;
                prio_d  = ~sel_q;
            end else begin
                cnt_d = cnt_q + c_CNT_W'(1);
            end
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            prio_q      <= 1'b0;
            sel_q       <= 1'b0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            prio_q      <= prio_d;
            sel_q       <= sel_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_last  = out_last_q;
    assign bus.sel       = sel_q;
    assign bus.busy      = (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_mux_2_to_1_rr_arbiter.sv
// +----------------------------------------------------------------------+
// | tb_mux_2_to_1_rr_arbiter: scoreboard bench for the 2:1 RR arbiter    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_mux_2_to_1_rr_arbiter;
    localparam int WIDTH     = 8;
    localparam int MAX_BURST = 4;

    typedef struct packed {
        logic [31:0] gap;
        logic [7:0]  d;
        logic        l;
    } item_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    item_t       src0_q[$];
    item_t       src1_q[$];
    logic [8:0]  exp_q[$];
    bit          hs0, hs1, loaded0, loaded1;
    int unsigned gap0, gap1;

    mux_2_to_1_rr_arbiter_if #(.WIDTH(WIDTH)) bus ();

    mux_2_to_1_rr_arbiter #(.WIDTH(WIDTH), .MAX_BURST(MAX_BURST)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        hs0 = rst_n && bus.req0_valid && bus.req0_ready;
        hs1 = rst_n && bus.req1_valid && bus.req1_ready;
    end

    // Requester models: pop on handshake, a per-item gap holds valid low first.
    always @(posedge clk) begin
        #1;
        if (hs0 && src0_q.size() > 0) begin src0_q.delete(0); loaded0 = 0; end
        if (src0_q.size() == 0) begin
            bus.req0_valid = 1'b0; loaded0 = 0;
        end else begin
            if (!loaded0) begin loaded0 = 1; gap0 = src0_q[0].gap; end
            else if (gap0 > 0) gap0--;
            bus.req0_valid = (gap0 == 0);
            bus.req0_data  = src0_q[0].d;
            bus.req0_last  = src0_q[0].l;
        end
        if (hs1 && src1_q.size() > 0) begin src1_q.delete(0); loaded1 = 0; end
        if (src1_q.size() == 0) begin
            bus.req1_valid = 1'b0; loaded1 = 0;
        end else begin
            if (!loaded1) begin loaded1 = 1; gap1 = src1_q[0].gap; end
            else if (gap1 > 0) gap1--;
            bus.req1_valid = (gap1 == 0);
            bus.req1_data  = src1_q[0].d;
            bus.req1_last  = src1_q[0].l;
        end
    end

    // Sink scoreboard: a transfer happens at the next edge when valid && ready.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL out_beat got=%h_%b want=none", bus.out_data, bus.out_last);
            end else if ({bus.out_data, bus.out_last} !== exp_q[0]) begin
                bad++;
                $display("FAIL out_beat got=%h_%b want=%h_%b", bus.out_data, bus.out_last,
                         exp_q[0][8:1], exp_q[0][0]);
                exp_q.delete(0);
            end else begin
                exp_q.delete(0);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        src0_q.delete(); src1_q.delete(); exp_q.delete();
        loaded0 = 0; loaded1 = 0;
        repeat (2) step();
    endtask

    task automatic push0(input logic [7:0] d, input logic l, input int unsigned gap);
        src0_q.push_back('{gap: gap, d: d, l: l});
    endtask

    task automatic push1(input logic [7:0] d, input logic l, input int unsigned gap);
        src1_q.push_back('{gap: gap, d: d, l: l});
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 60) begin step(); n++; end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s_drain left=%0d want=0", name, exp_q.size());
        end
    endtask

    task automatic test_reset();
        apply_reset();
        bus.out_ready = 1'b1;
        push0(8'h11, 1'b0, 0); push0(8'h22, 1'b1, 0); push1(8'h33, 1'b1, 0);
        exp_q.push_back({8'h11, 1'b0}); exp_q.push_back({8'h22, 1'b1});
        exp_q.push_back({8'h33, 1'b1});
        repeat (2) step();
        rst_n = 1'b1;
        total++;
        if ({bus.busy, bus.out_valid, bus.out_data, bus.out_last, bus.sel,
             bus.req0_ready, bus.req1_ready} !== 14'b0) begin
            bad++;
            $display("FAIL reset_state got=%b_%b_%h_%b_%b_%b_%b want=all zero", bus.busy,
                     bus.out_valid, bus.out_data, bus.out_last, bus.sel, bus.req0_ready, bus.req1_ready);
        end
        step();
        total++;
        if (bus.busy !== 1'b1 || bus.sel !== 1'b0 || bus.req0_ready !== 1'b1 ||
            bus.req1_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL grant0 got busy=%b sel=%b r0=%b r1=%b ov=%b want 1 0 1 0 0",
                     bus.busy, bus.sel, bus.req0_ready, bus.req1_ready, bus.out_valid);
        end
        step();
        total++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h11 || bus.out_last !== 1'b0) begin
            bad++;
            $display("FAIL first_beat got=%b_%h_%b want=1_11_0", bus.out_valid, bus.out_data, bus.out_last);
        end
        step();
        total++;
        if (bus.out_data !== 8'h22 || bus.out_last !== 1'b1 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL last_beat got=%h_%b busy=%b want=22_1 busy=0", bus.out_data, bus.out_last, bus.busy);
        end
        step();
        total++;
        if (bus.busy !== 1'b1 || bus.sel !== 1'b1) begin
            bad++;
            $display("FAIL grant1 got busy=%b sel=%b want 1 1", bus.busy, bus.sel);
        end
        drain("reset");
    endtask

    task automatic test_burst_cap();
        int n;
        apply_reset();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            push0(8'(i), 1'b0, 0);
            push1(8'(8'h10 + i), 1'b0, 0);
        end
        for (int i = 0; i < 4; i++) exp_q.push_back({8'(i), 1'b0});
        for (int i = 0; i < 4; i++) exp_q.push_back({8'(8'h10 + i), 1'b0});
        for (int i = 4; i < 8; i++) exp_q.push_back({8'(i), 1'b0});
        for (int i = 4; i < 8; i++) exp_q.push_back({8'(8'h10 + i), 1'b0});
        step();
        rst_n = 1'b1;
        for (int g = 0; g < 4; g++) begin
            n = 0;
            while (!bus.busy && n < 20) begin step(); n++; end
            total++;
            if (bus.sel !== 1'(g % 2)) begin
                bad++;
                $display("FAIL cap_sel grant=%0d got=%b want=%b", g, bus.sel, 1'(g % 2));
            end
            n = 0;
            while (bus.busy && n < 20) begin step(); n++; end
            total++;
            if (n != MAX_BURST) begin
                bad++;
                $display("FAIL cap_len grant=%0d got=%0d want=%0d", g, n, MAX_BURST);
            end
            if (g < 3) begin
                n = 0;
                while (!bus.busy && n < 20) begin step(); n++; end
                total++;
                if (n != 1) begin
                    bad++;
                    $display("FAIL cap_idle grant=%0d got=%0d want=1", g, n);
                end
            end
        end
        drain("cap");
    endtask

    task automatic test_backpressure();
        int n;
        apply_reset();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push0(8'(8'h40 + i), 1'(i == 3), 0);
            exp_q.push_back({8'(8'h40 + i), 1'(i == 3)});
        end
        step();
        rst_n = 1'b1;
        n = 0;
        while (!bus.out_valid && n < 20) begin step(); n++; end
        for (int c = 0; c < 5; c++) begin
            step();
            total++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h40 || bus.req0_ready !== 1'b0) begin
                bad++;
                $display("FAIL bp_hold cyc=%0d got=%b_%h r0=%b want=1_40 r0=0", c,
                         bus.out_valid, bus.out_data, bus.req0_ready);
            end
        end
        bus.out_ready = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 60) begin step(); n++; end
        total++;
        if (n != 4) begin
            bad++;
            $display("FAIL bp_rate got=%0d cycles want=4", n);
        end
        drain("bp");
    endtask

    task automatic test_single_beat();
        int n;
        apply_reset();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push1(8'(8'hA0 + i), 1'b1, 0);
            exp_q.push_back({8'(8'hA0 + i), 1'b1});
        end
        step();
        rst_n = 1'b1;
        for (int g = 0; g < 4; g++) begin
            n = 0;
            while (!bus.busy && n < 20) begin step(); n++; end
            total++;
            if (bus.sel !== 1'b1) begin
                bad++;
                $display("FAIL single_sel grant=%0d got=%b want=1", g, bus.sel);
            end
            n = 0;
            while (bus.busy && n < 20) begin step(); n++; end
            total++;
            if (n != 1) begin
                bad++;
                $display("FAIL single_len grant=%0d got=%0d want=1", g, n);
            end
            if (g < 3) begin
                n = 0;
                while (!bus.busy && n < 20) begin step(); n++; end
                total++;
                if (n != 1) begin
                    bad++;
                    $display("FAIL single_idle grant=%0d got=%0d want=1", g, n);
                end
            end
        end
        drain("single");
    endtask

    task automatic test_async_reset();
        int n;
        apply_reset();
        bus.out_ready = 1'b0;
        push0(8'h50, 1'b0, 0); push0(8'h51, 1'b0, 0);
        step();
        rst_n = 1'b1;
        n = 0;
        while (!bus.out_valid && n < 20) begin step(); n++; end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.out_data !== 8'h00) begin
            bad++;
            $display("FAIL async_rst got ov=%b busy=%b data=%h want 0 0 00",
                     bus.out_valid, bus.busy, bus.out_data);
        end
        src0_q.delete(); src1_q.delete(); loaded0 = 0; loaded1 = 0;
        for (int i = 0; i < 4; i++) begin
            push0(8'(8'h60 + i), 1'b0, 0);
            exp_q.push_back({8'(8'h60 + i), 1'b0});
        end
        push1(8'h70, 1'b1, 0);
        exp_q.push_back({8'h70, 1'b1});
        bus.out_ready = 1'b1;
        repeat (2) step();
        rst_n = 1'b1;
        n = 0;
        while (!bus.busy && n < 20) begin step(); n++; end
        total++;
        if (bus.sel !== 1'b0) begin
            bad++;
            $display("FAIL post_rst_prio got sel=%b want=0", bus.sel);
        end
        n = 0;
        while (bus.busy && n < 20) begin step(); n++; end
        total++;
        if (n != MAX_BURST) begin
            bad++;
            $display("FAIL post_rst_cnt got=%0d want=%0d", n, MAX_BURST);
        end
        drain("async");
    endtask

    task automatic test_owner_gap();
        int n;
        apply_reset();
        bus.out_ready = 1'b1;
        push0(8'h80, 1'b0, 0); push0(8'h81, 1'b0, 3); push0(8'h82, 1'b1, 0);
        push1(8'h90, 1'b1, 0);
        exp_q.push_back({8'h80, 1'b0}); exp_q.push_back({8'h81, 1'b0});
        exp_q.push_back({8'h82, 1'b1}); exp_q.push_back({8'h90, 1'b1});
        step();
        rst_n = 1'b1;
        n = 0;
        while (!bus.busy && n < 20) begin step(); n++; end
        n = 0;
        while (bus.busy && n < 20) begin
            total++;
            if (bus.sel !== 1'b0 || bus.req1_ready !== 1'b0) begin
                bad++;
                $display("FAIL gap_hold cyc=%0d got sel=%b r1=%b want 0 0", n, bus.sel, bus.req1_ready);
            end
            step(); n++;
        end
        total++;
        if (n != 6) begin
            bad++;
            $display("FAIL gap_len got=%0d want=6", n);
        end
        n = 0;
        while (!bus.busy && n < 20) begin step(); n++; end
        total++;
        if (bus.sel !== 1'b1) begin
            bad++;
            $display("FAIL gap_prio got sel=%b want=1", bus.sel);
        end
        drain("gap");
    endtask

    initial begin
        bus.req0_valid = 1'b0; bus.req0_data = '0; bus.req0_last = 1'b0;
        bus.req1_valid = 1'b0; bus.req1_data = '0; bus.req1_last = 1'b0;
        bus.out_ready  = 1'b0;
        test_reset();
        test_burst_cap();
        test_backpressure();
        test_single_beat();
        test_async_reset();
        test_owner_gap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
